operand_accumulator_8_bit: RTL

//  Sequential front end that feeds ripple_carry_adder_8_bit. Accepts NUM_OPS 8-bit operands

---
 rtl/operand_accumulator_8_bit_pkg.sv | 12 +
 rtl/operand_accumulator_8_bit_if.sv | 34 +++
 rtl/operand_accumulator_8_bit_rca.sv | 26 ++
 rtl/operand_accumulator_8_bit.sv | 109 ++++++++++
 4 files changed

// File: rtl/operand_accumulator_8_bit_pkg.sv
// Shared definitions for the 8-bit operand accumulator: datapath width and FSM state encodings.
package operand_accumulator_8_bit_pkg;

    localparam int DATA_W = 8;

    typedef enum logic [1:0] {
        S_IDLE  = 2'd0,
        S_ACCUM = 2'd1,
        S_HOLD  = 2'd2
    } accState_e;

endpackage

// File: rtl/operand_accumulator_8_bit_if.sv
// Operand input stream and result output stream of the accumulator, both valid/ready.
// The master side is the operand source / result consumer; the slave side is the accumulator.
interface operand_accumulator_8_bit_if;
    import operand_accumulator_8_bit_pkg::*;

    logic              in_valid;
    logic              in_ready;
    logic [DATA_W-1:0] in_data;
    logic              out_valid;
    logic              out_ready;
    logic [DATA_W-1:0] out_sum;
    logic              out_carry;

    modport master (
        output in_valid,
        output in_data,
        output out_ready,
        input  in_ready,
        input  out_valid,
        input  out_sum,
        input  out_carry
    );

    modport slave (
        input  in_valid,
        input  in_data,
        input  out_ready,
        output in_ready,
        output out_valid,
        output out_sum,
        output out_carry
    );

endinterface

// File: rtl/operand_accumulator_8_bit_rca.sv
// Purely combinational ripple-carry adder built from a chain of full adders.
module ripple_carry_adder_8_bit
    import operand_accumulator_8_bit_pkg::*;
(
    input  logic [DATA_W-1:0] a_i,
    input  logic [DATA_W-1:0] b_i,
    input  logic              c0_i,
    output logic [DATA_W-1:0] sum_o,
    output logic              c8_o
);

    logic [DATA_W:0] carry;

    assign carry[0] = c0_i;

    genvar i;
    generate
        for (i = 0; i < DATA_W; i++) begin : g_fa
            assign sum_o[i]     = a_i[i] ^ b_i[i] ^ carry[i];
            assign carry[i + 1] = (a_i[i] & b_i[i]) | (carry[i] & (a_i[i] ^ b_i[i]));
        end
    endgenerate

    assign c8_o = carry[DATA_W];

endmodule

// File: rtl/operand_accumulator_8_bit.sv
// Folds NUM_OPS operands into a running 8-bit sum with a sticky carry flag.
// Optional build macro SATURATE_EN clamps the sum to 8'hFF on carry-out instead of wrapping.
module operand_accumulator_8_bit
    import operand_accumulator_8_bit_pkg::*;
#(
    parameter int unsigned NUM_OPS = 4,
    parameter int unsigned CNT_W   = 8
) (
    input  logic                        clk,
    input  logic                        rst,
    operand_accumulator_8_bit_if.slave  bus
);

    localparam logic [CNT_W-1:0] LAST_CNT = CNT_W'(NUM_OPS - 1);

    accState_e         state_q, state_d;
    logic [DATA_W-1:0] acc_q, acc_d;
    logic [CNT_W-1:0]  cnt_q, cnt_d;
    logic              flag_q, flag_d;

    logic              inReady;
    logic              accept;
    logic [DATA_W-1:0] adderA;
    logic [DATA_W-1:0] addSum;
    logic              addC8;
    logic [DATA_W-1:0] nextAcc;

    assign inReady = (state_q == S_IDLE) || (state_q == S_ACCUM);
    assign accept  = bus.in_valid & inReady;

    // A fresh sum starts from zero regardless of what the accumulator register holds
    assign adderA = (state_q == S_IDLE) ? '0 : acc_q;

    ripple_carry_adder_8_bit u_adder (
        .a_i   (adderA),
        .b_i   (bus.in_data),
        .c0_i  (1'b0),
        .sum_o (addSum),
        .c8_o  (addC8)
    );

`ifdef SATURATE_EN
    assign nextAcc = addC8 ? '1 : addSum;
`else
    assign nextAcc = addSum;
`endif

    always_ff @(posedge clk) begin
        if (rst) begin
            state_q <= S_IDLE;
            acc_q   <= '0;
            cnt_q   <= '0;
            flag_q  <= 1'b0;
        end else begin
            state_q <= state_d;
            acc_q   <= acc_d;
            cnt_q   <= cnt_d;
            flag_q  <= flag_d;
        end
    end

    always_comb begin
        state_d = state_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        flag_d  = flag_q;
        case (state_q)
            S_IDLE: begin
                if (accept) begin
                    acc_d   = nextAcc;
                    cnt_d   = CNT_W'(1);
                    flag_d  = 1'b0;
                    state_d = (NUM_OPS == 1) ? S_HOLD : S_ACCUM;
                end
            end
            S_ACCUM: begin
                if (accept) begin
                    acc_d  = nextAcc;
                    flag_d = flag_q | addC8;
                    cnt_d  = cnt_q + CNT_W'(1);
                    if (cnt_q == LAST_CNT) begin
                        state_d = S_HOLD;
                    end
                end
            end
            S_HOLD: begin
                if (bus.out_ready) begin
                    state_d = S_IDLE;
                    acc_d   = '0;
                    cnt_d   = '0;
                    flag_d  = 1'b0;
                end
            end
            default: begin
                state_d = S_IDLE;
                acc_d   = '0;
                cnt_d   = '0;
                flag_d  = 1'b0;
            end
        endcase
    end

    // Result is only presented while holding; partial sums never leak to the output
    assign bus.in_ready  = inReady;
    assign bus.out_valid = (state_q == S_HOLD);
    assign bus.out_sum   = (state_q == S_HOLD) ? acc_q : '0;
    assign bus.out_carry = (state_q == S_HOLD) ? flag_q : 1'b0;

endmodule
